huff_word_packer: RTL and testbench



---
 rtl/huff_pack_pkg.sv | 19 +
 rtl/pack_shift_320.sv | 21 ++
 rtl/huff_word_packer.sv | 133 +++++++++++++
 tb/tb_huff_word_packer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/huff_pack_pkg.sv
// Shared widths and FSM encoding for the Huffman word packer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package huff_pack_pkg;

  localparam int OUT_W  = 64;   // output word width
  localparam int IN_W   = 256;  // input chunk width
  localparam int LEN_W  = 8;    // in_len width, 0..255
  localparam int BUF_W  = 320;  // residual buffer; max fill 63+255=318
  localparam int CNT_W  = 9;    // buffer fill count, 0..318
  localparam int BITS_W = 7;    // out_bits width, 0..64

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,  // fill < 64, taking chunks
    ST_DRAIN  = 2'd1,  // fill >= 64, emitting full words
    ST_FLUSH  = 2'd2   // last chunk taken, emitting remainder
  } state_e;

endpackage

// File: rtl/pack_shift_320.sv
// Merges an LSB-first chunk into the residual buffer above its current fill.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is committed.
// Ports: buf_i current buffer, data_i chunk, shamt_i fill count, buf_o merged.
module pack_shift_320
  import huff_pack_pkg::*;
(
  input  logic [BUF_W-1:0] buf_i,
  input  logic [IN_W-1:0]  data_i,
  input  logic [CNT_W-1:0] shamt_i,
  output logic [BUF_W-1:0] buf_o
);

  logic [BUF_W-1:0] data_ext;

  // Bits of buf_i at/above shamt_i are zero and bits of data_i at/above
  // in_len are zero, so a plain OR is a lossless append.
  assign data_ext = {{(BUF_W-IN_W){1'b0}}, data_i};
  assign buf_o    = buf_i | (data_ext << shamt_i);

endmodule

// File: rtl/huff_word_packer.sv
// Repacks variable-length LSB-first chunks into 64-bit words; final word zero-padded with bit count.
// Latency: word valid the cycle after the accept that fills 64 bits or carries in_last.
// Backpressure: in_ready low whenever a word is pending; word held stable until out_ready.
// Ports: clk/reset (async active-low); in_valid/in_ready/in_data/in_len/in_last chunk side;
//        out_valid/out_ready/out_data/out_last/out_bits word side.
module huff_word_packer
  import huff_pack_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic [LEN_W-1:0]  in_len,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  output logic [BITS_W-1:0] out_bits
);

  localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(OUT_W);

  state_e             state_q, state_d;
  logic [BUF_W-1:0]   acc_q, acc_d, acc_merged;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic [BITS_W-1:0]  out_bits_q, out_bits_d;

  logic               acc_fire;
  logic               out_fire;

  pack_shift_320 u_shift (
    .buf_i   (acc_q),
    .data_i  (in_data),
    .shamt_i (cnt_q),
    .buf_o   (acc_merged)
  );

  // Handshakes use the registered flags so nothing combinational from the
  // opposite side leaks into the state decision beyond the qualifier.
  assign acc_fire = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_ACCEPT: begin
        if (acc_fire) begin
          acc_d = acc_merged;
          cnt_d = cnt_q + CNT_W'(in_len);
          if (in_last) begin
            state_d = ST_FLUSH;
          end else if (cnt_d >= CNT_WORD) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (out_fire) begin
          acc_d = acc_q >> OUT_W;
          cnt_d = cnt_q - CNT_WORD;
          if (cnt_d < CNT_WORD) begin
            state_d = ST_ACCEPT;
          end
        end
      end
      ST_FLUSH: begin
        if (out_fire) begin
          if (cnt_q > CNT_WORD) begin
            acc_d = acc_q >> OUT_W;
            cnt_d = cnt_q - CNT_WORD;
          end else begin
            // Final word gone: start the next stream from a clean buffer.
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ST_ACCEPT;
          end
        end
      end
      default: begin
        state_d = ST_ACCEPT;
      end
    endcase
  end

  // Outputs are precomputed from next-state values so they are plain flops.
  always_comb begin
    in_ready_d  = (state_d == ST_ACCEPT);
    out_valid_d = (state_d != ST_ACCEPT);
    out_data_d  = out_valid_d ? acc_d[OUT_W-1:0] : '0;
    // Empty stream reaches here with cnt 0 and reports out_bits = 0.
    out_last_d  = (state_d == ST_FLUSH) && (cnt_d <= CNT_WORD);
    out_bits_d  = out_last_d ? cnt_d[BITS_W-1:0] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_ACCEPT;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_bits_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_bits_q  <= out_bits_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_bits  = out_bits_q;

endmodule

// File: tb/tb_huff_word_packer.sv
// Bench for huff_word_packer: table vectors, directed corner sequences,
// and randomized streams scored against a bit-queue reference model.
module tb_huff_word_packer;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic [7:0]   in_len;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic         out_last;
  logic [6:0]   out_bits;

  always #5 clk = ~clk;

  huff_word_packer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_len    (in_len),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_bits  (out_bits)
  );

  typedef struct {
    logic [63:0] d;
    logic        last;
    logic [6:0]  bits;
  } word_t;

  typedef struct {
    logic [255:0]      d;
    logic [7:0]        len;
    int                nw;
    logic [3:0][63:0]  w;
    logic [6:0]        bits;
  } vec_t;

  word_t exp_q[$];
  word_t obs_q[$];
  bit    mq[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic        prev_stall = 1'b0;
  logic [63:0] prev_d;
  logic        prev_last;
  logic [6:0]  prev_bits;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_to(input string name);
    n_checks++;
    $display("FAIL %s: timed out, got no response, expected a handshake", name);
  endtask

  // Reference model: the stream is just a queue of bits.
  function automatic word_t pop_word(input logic last);
    word_t w;
    int n;
    n = mq.size();
    w.d = '0;
    for (int i = 0; i < 64; i++) if (mq.size() > 0) w.d[i] = mq.pop_front();
    w.last = last;
    w.bits = last ? 7'(n) : 7'd0;
    return w;
  endfunction

  function automatic void model_accept(input logic [255:0] d, input logic [7:0] l, input logic last);
    for (int i = 0; i < int'(l); i++) mq.push_back(d[i]);
    if (last) begin
      while (mq.size() > 64) exp_q.push_back(pop_word(1'b0));
      exp_q.push_back(pop_word(1'b1));
    end else begin
      while (mq.size() >= 64) exp_q.push_back(pop_word(1'b0));
    end
  endfunction

  // Monitor: samples on the falling edge; handshakes complete at the next rise.
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      chk("ready_valid_excl", 64'(in_ready && out_valid), 64'd0);
      if (prev_stall && out_valid) begin
        chk("hold_data", out_data, prev_d);
        chk("hold_last", 64'(out_last), 64'(prev_last));
        chk("hold_bits", 64'(out_bits), 64'(prev_bits));
      end
      if (in_valid && in_ready) model_accept(in_data, in_len, in_last);
      if (out_valid && out_ready) begin
        word_t o;
        o.d = out_data; o.last = out_last; o.bits = out_bits;
        obs_q.push_back(o);
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_word", out_data, 64'd0);
          chk("sb_unexpected_word_count", 64'd1, 64'd0);
        end else begin
          word_t e;
          e = exp_q.pop_front();
          chk("sb_data", out_data, e.d);
          chk("sb_last", 64'(out_last), 64'(e.last));
          if (e.last) chk("sb_bits", 64'(out_bits), 64'(e.bits));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data; prev_last = out_last; prev_bits = out_bits;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [255:0] d, input logic [7:0] l, input logic last);
    int t;
    in_valid = 1'b1; in_data = d; in_len = l; in_last = last;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) fail_to("send_accept");
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = '0; in_len = '0; in_last = 1'b0;
  endtask

  task automatic wait_obs(input int n);
    int t;
    t = 0;
    while (obs_q.size() < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (obs_q.size() < n) fail_to("wait_words");
    @(posedge clk); #1;
  endtask

  task automatic chk_obs(input string name, input int idx, input logic [63:0] d,
                         input logic last, input logic [6:0] bits);
    if (obs_q.size() <= idx) begin
      fail_to(name);
    end else begin
      chk({name, "_data"}, obs_q[idx].d, d);
      chk({name, "_last"}, 64'(obs_q[idx].last), 64'(last));
      if (last) chk({name, "_bits"}, 64'(obs_q[idx].bits), 64'(bits));
    end
  endtask

  function automatic logic [255:0] rand_chunk(input logic [7:0] l);
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
    for (int i = 0; i < 256; i++) if (i >= int'(l)) d[i] = 1'b0;
    return d;
  endfunction

  vec_t vecs[6];
  logic [255:0] bp_d;
  logic [255:0] ones;
  bit           done;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_len = '0; in_last = 1'b0;
    out_ready = 1'b1;
    #2 reset = 1'b0;

    // ---- table of single-chunk terminated streams ----
    ones = '0;
    for (int i = 0; i < 255; i++) ones[i] = 1'b1;
    vecs[0].d = 256'h0123456789ABCDEF; vecs[0].len = 8'd64; vecs[0].nw = 1;
    vecs[0].w = '0; vecs[0].w[0] = 64'h0123456789ABCDEF; vecs[0].bits = 7'd64;
    vecs[1].d = '0; vecs[1].len = 8'd0; vecs[1].nw = 1;
    vecs[1].w = '0; vecs[1].bits = 7'd0;
    vecs[2].d = ones; vecs[2].len = 8'd255; vecs[2].nw = 4;
    vecs[2].w[0] = 64'hFFFF_FFFF_FFFF_FFFF; vecs[2].w[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    vecs[2].w[2] = 64'hFFFF_FFFF_FFFF_FFFF; vecs[2].w[3] = 64'h7FFF_FFFF_FFFF_FFFF;
    vecs[2].bits = 7'd63;
    vecs[3].d = 256'h5A; vecs[3].len = 8'd8; vecs[3].nw = 1;
    vecs[3].w = '0; vecs[3].w[0] = 64'h5A; vecs[3].bits = 7'd8;
    vecs[4].d = 256'h1_0000_0000_0000_1234; vecs[4].len = 8'd65; vecs[4].nw = 2;
    vecs[4].w = '0; vecs[4].w[0] = 64'h1234; vecs[4].w[1] = 64'h1; vecs[4].bits = 7'd1;
    vecs[5].d = 256'hCAFE_F00D_DEAD_BEEF_1111_2222_3333_4444; vecs[5].len = 8'd128; vecs[5].nw = 2;
    vecs[5].w = '0; vecs[5].w[0] = 64'h1111_2222_3333_4444;
    vecs[5].w[1] = 64'hCAFE_F00D_DEAD_BEEF; vecs[5].bits = 7'd64;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_bits", 64'(out_bits), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    chk("rel_out_valid", 64'(out_valid), 64'd0);

    for (int v = 0; v < 6; v++) begin
      obs_q.delete();
      send(vecs[v].d, vecs[v].len, 1'b1);
      wait_obs(vecs[v].nw);
      for (int j = 0; j < vecs[v].nw; j++)
        chk_obs($sformatf("tbl%0d_w%0d", v, j), j, vecs[v].w[j],
                (j == vecs[v].nw - 1), vecs[v].bits);
      chk($sformatf("tbl%0d_count", v), 64'(obs_q.size()), 64'(vecs[v].nw));
      chk($sformatf("tbl%0d_back_to_accept", v), 64'(in_ready), 64'd1);
    end

    // ---- four 16-bit chunks make one word ----
    obs_q.delete();
    send(256'hAAAA, 8'd16, 1'b0);
    send(256'hBBBB, 8'd16, 1'b0);
    send(256'hCCCC, 8'd16, 1'b0);
    chk("four_no_word_yet", 64'(out_valid), 64'd0);
    send(256'hDDDD, 8'd16, 1'b0);
    chk("four_valid_next", 64'(out_valid), 64'd1);
    chk("four_ready_low", 64'(in_ready), 64'd0);
    chk("four_data", out_data, 64'hDDDDCCCCBBBBAAAA);
    chk("four_not_last", 64'(out_last), 64'd0);
    wait_obs(1);
    chk("four_back_ready", 64'(in_ready), 64'd1);

    // ---- backpressure during drain ----
    bp_d = rand_chunk(8'd255);
    out_ready = 1'b0;
    send(bp_d, 8'd255, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_ready_low", 64'(in_ready), 64'd0);
      chk("bp_data", out_data, bp_d[63:0]);
    end
    @(posedge clk); #1;
    obs_q.delete();
    out_ready = 1'b1;
    wait_obs(3);
    chk_obs("bp_w0", 0, bp_d[63:0], 1'b0, 7'd0);
    chk_obs("bp_w1", 1, bp_d[127:64], 1'b0, 7'd0);
    chk_obs("bp_w2", 2, bp_d[191:128], 1'b0, 7'd0);
    obs_q.delete();
    send('0, 8'd0, 1'b1);
    wait_obs(1);
    chk_obs("bp_tail", 0, {1'b0, bp_d[254:192]}, 1'b1, 7'd63);

    // ---- reset while a 40-bit final word is pending ----
    out_ready = 1'b0;
    send(rand_chunk(8'd40), 8'd40, 1'b1);
    chk("rf_valid", 64'(out_valid), 64'd1);
    chk("rf_last", 64'(out_last), 64'd1);
    chk("rf_bits", 64'(out_bits), 64'd40);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rf_rst_valid", 64'(out_valid), 64'd0);
    chk("rf_rst_ready", 64'(in_ready), 64'd0);
    chk("rf_rst_data", out_data, 64'd0);
    chk("rf_rst_last", 64'(out_last), 64'd0);
    chk("rf_rst_bits", 64'(out_bits), 64'd0);
    mq.delete(); exp_q.delete(); obs_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    chk("rf_rel_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("rf_rel_ready", 64'(in_ready), 64'd1);
    chk("rf_rel_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    send(256'h5A, 8'd8, 1'b1);
    wait_obs(1);
    chk_obs("rf_new", 0, 64'h5A, 1'b1, 7'd8);
    chk("rf_new_count", 64'(obs_q.size()), 64'd1);

    // ---- randomized streams with random downstream stalls ----
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 60; n++) begin
          logic [7:0] l;
          l = 8'($urandom_range(0, 255));
          send(rand_chunk(l), l, ($urandom_range(0, 5) == 0));
        end
        send('0, 8'd0, 1'b1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    begin
      int t;
      t = 0;
      while (exp_q.size() > 0 && t < 1000) begin
        @(negedge clk);
        t++;
      end
    end
    chk("rand_all_words_out", 64'(exp_q.size()), 64'd0);
    chk("rand_model_empty", 64'(mq.size()), 64'd0);
    repeat (3) @(negedge clk);
    chk("rand_idle_valid", 64'(out_valid), 64'd0);
    chk("rand_idle_ready", 64'(in_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
